// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding and UartTx frame constant
//   FRAME_BITS : bits per UartTx frame (start + 8 data + parity + stop bits)
//   state_t    : arbiter sequencing states, 2-bit encoded
package uart_tx_arbiter_pkg;
    localparam int FRAME_BITS = 12;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LATCH      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin pick starting after ptr
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    most recent winner; search begins at ptr+1 and wraps
//   found out 1        at least one request is set
//   idx   out IDX_W    first set request in rotated order
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] j;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one UartTx
//   clk, nrst          clock, asynchronous active-low reset
//   req_valid/data/last per-requester byte, byte i at req_data[8i+7:8i]
//   req_ready           one-cycle pulse when byte i is taken by UartTx
//   tx_data, tx_latch   to UartTx data / latch_data
//   tx_busy             from UartTx busy
//   grant_idx           current or most recent winner
//   grant_active        transfer or message lock in progress
//   err_timeout         one-cycle pulse when busy never rose after a latch
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDX_W         = 2,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_latch,
    input  logic                 tx_busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_active,
    output logic                 err_timeout
);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    state_t           state;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic             last_cap;
    logic [CNT_W-1:0] tmo_cnt;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_ok;
    logic [IDX_W-1:0] sel_idx;
    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );
    // While locked only the message owner may be served, even if others wait.
    assign sel_ok    = lock ? req_valid[winner] : pick_found;
    assign sel_idx   = lock ? winner : pick_idx;
    assign grant_idx = winner;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            winner       <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            lock         <= 1'b0;
            last_cap     <= 1'b0;
            tmo_cnt      <= '0;
            tx_data      <= '0;
            tx_latch     <= 1'b0;
            req_ready    <= '0;
            grant_active <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            tx_latch    <= 1'b0;
            req_ready   <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (!tx_busy && sel_ok) begin
                    winner       <= sel_idx;
                    tx_data      <= req_data[8*int'(sel_idx) +: 8];
                    grant_active <= 1'b1;
                    state        <= LATCH;
                end
                LATCH: begin
                    tx_latch <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= WAIT_START;
                end
                // A timeout leaves rr_ptr alone so the same byte is retried.
                WAIT_START: if (tx_busy) begin
                    req_ready[winner] <= 1'b1;
                    last_cap          <= req_last[winner];
                    state             <= WAIT_DONE;
                end else if (tmo_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    err_timeout  <= 1'b1;
                    tmo_cnt      <= CNT_W'(START_TIMEOUT);
                    grant_active <= lock;
                    state        <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    rr_ptr       <= winner;
                    lock         <= !last_cap;
                    grant_active <= !last_cap;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench with a UartTx busy model
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;
    localparam int BAUD = 2;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_latch;
    logic        tx_busy;
    logic [1:0]  grant_idx;
    logic        grant_active;
    logic        err_timeout;
    logic        mbusy = 1'b0;
    int          bcnt = 0;
    logic        force_busy = 1'b0;
    logic        no_start = 1'b0;
    logic [8:0]  pbuf [4][8];
    int          head [4];
    int          tail [4];
    logic [7:0]  seen [64];
    int          nseen = 0;
    int          nlatch = 0;
    int          nerr = 0;
    int          nready [4];
    logic [3:0]  pv = '0;
    int          total = 0;
    int          bad = 0;
    int          k;
    int          base;
    int          r2;
    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .START_TIMEOUT(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_latch     (tx_latch),
        .tx_busy      (tx_busy),
        .grant_idx    (grant_idx),
        .grant_active (grant_active),
        .err_timeout  (err_timeout)
    );
    always #5 clk = ~clk;
    assign tx_busy = mbusy | force_busy;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = head[i] != tail[i];
            req_data[8*i +: 8]  = pbuf[i][head[i] % 8][7:0];
            req_last[i]         = pbuf[i][head[i] % 8][8];
        end
    end
    initial for (int i = 0; i < 4; i++) begin
        head[i] = 0;
        tail[i] = 0;
        nready[i] = 0;
        for (int j = 0; j < 8; j++) pbuf[i][j] = '0;
    end
    // Producers retire a byte once its ready pulse has been seen.
    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (req_ready[i]) head[i] = head[i] + 1;
    always @(posedge clk) begin
        if (tx_latch) nlatch++;
        if (err_timeout) nerr++;
        for (int i = 0; i < 4; i++) if (req_ready[i]) nready[i]++;
        if (nrst) begin
            for (int i = 0; i < 4; i++)
                if (pv[i] && !req_ready[i]) chk("valid_hold", {31'd0, req_valid[i]}, 32'd1);
            pv = req_valid;
        end else begin
            pv = '0;
        end
        if (mbusy) begin
            if (bcnt == 1) mbusy <= 1'b0;
            bcnt <= bcnt - 1;
        end else if (tx_latch && !no_start) begin
            mbusy <= 1'b1;
            bcnt  <= FRAME_BITS * BAUD;
            seen[nseen] = tx_data;
            nseen++;
        end
    end
    task automatic push(input int i, input logic [7:0] d, input logic l);
        pbuf[i][tail[i] % 8] = {l, d};
        tail[i] = tail[i] + 1;
    endtask
    task automatic wait_latch(output int n);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (tx_latch) break;
        end
    endtask
    task automatic wait_quiet();
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (req_valid == 4'd0 && !grant_active && !tx_busy) return;
        end
        chk("quiet_timeout", 32'd0, 32'd1);
    endtask
    task automatic reset_pulse();
        @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {15'd0, tx_data, tx_latch, req_ready, grant_idx, grant_active, err_timeout}, 32'd0);
        nrst = 1'b1;
        // 1: single byte, latency and grant
        @(posedge clk);
        #1 push(0, 8'h41, 1'b1);
        wait_latch(k);
        chk("t1_latch_lat", k, 2);
        chk("t1_tx_data", {24'd0, tx_data}, 32'h41);
        chk("t1_grant_idx", {30'd0, grant_idx}, 0);
        for (k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (req_ready[0]) break;
        end
        chk("t1_ready_lat", k, 2);
        wait_quiet();
        chk("t1_ready_cnt", nready[0], 1);
        chk("t1_seen_n", nseen, 1);
        chk("t1_seen", {24'd0, seen[0]}, 32'h41);
        // 2: all valid and last, strict rotation from requester 0
        reset_pulse();
        base = nseen;
        for (int i = 0; i < 4; i++) push(i, 8'h30 + 8'(i), 1'b1);
        push(0, 8'h30, 1'b1);
        wait_quiet();
        chk("t2_seen_n", nseen - base, 5);
        chk("t2_b0", {24'd0, seen[base]},     32'h30);
        chk("t2_b1", {24'd0, seen[base + 1]}, 32'h31);
        chk("t2_b2", {24'd0, seen[base + 2]}, 32'h32);
        chk("t2_b3", {24'd0, seen[base + 3]}, 32'h33);
        chk("t2_b4", {24'd0, seen[base + 4]}, 32'h30);
        chk("t2_rdy0", nready[0], 3);
        chk("t2_rdy1", nready[1], 1);
        chk("t2_rdy3", nready[3], 1);
        // 3: locked message from req1, req2 starves even across an owner gap
        base = nseen;
        r2 = nready[2];
        push(1, 8'hA0, 1'b0);
        push(1, 8'hA1, 1'b0);
        push(2, 8'hB0, 1'b1);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (nseen - base == 2 && !tx_busy) break;
        end
        repeat (40) @(posedge clk);
        #1;
        chk("t3_gap_seen", nseen - base, 2);
        chk("t3_gap_active", {31'd0, grant_active}, 1);
        chk("t3_gap_idx", {30'd0, grant_idx}, 1);
        chk("t3_gap_rdy2", nready[2] - r2, 0);
        push(1, 8'hA2, 1'b1);
        wait_quiet();
        chk("t3_seen_n", nseen - base, 4);
        chk("t3_b0", {24'd0, seen[base]},     32'hA0);
        chk("t3_b1", {24'd0, seen[base + 1]}, 32'hA1);
        chk("t3_b2", {24'd0, seen[base + 2]}, 32'hA2);
        chk("t3_b3", {24'd0, seen[base + 3]}, 32'hB0);
        // 4: UartTx never starts, timeout then retry of the same byte
        base = nseen;
        no_start = 1'b1;
        @(posedge clk);
        #1 push(3, 8'hC3, 1'b1);
        wait_latch(k);
        chk("t4_latch_lat", k, 2);
        chk("t4_idx", {30'd0, grant_idx}, 3);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (err_timeout) break;
        end
        chk("t4_tmo_lat", k, 8);
        chk("t4_no_ready", nready[3], 1);
        wait_latch(k);
        no_start = 1'b0;
        chk("t4_retry_lat", k, 2);
        chk("t4_retry_data", {24'd0, tx_data}, 32'hC3);
        wait_quiet();
        chk("t4_rdy3", nready[3], 2);
        chk("t4_err_cnt", nerr, 1);
        chk("t4_seen_n", nseen - base, 1);
        chk("t4_seen", {24'd0, seen[base]}, 32'hC3);
        // 5: reset in WAIT_DONE while a frame is in flight
        push(2, 8'hD2, 1'b1);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (req_ready[2]) break;
        end
        @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("t5_rst_outs", {15'd0, tx_data, tx_latch, req_ready, grant_idx, grant_active, err_timeout}, 32'd0);
        chk("t5_busy_on", {31'd0, tx_busy}, 1);
        @(posedge clk);
        #1 nrst = 1'b1;
        base = nseen;
        k = nlatch;
        push(3, 8'hF3, 1'b1);
        push(0, 8'hE0, 1'b1);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (!tx_busy) break;
        end
        chk("t5_no_latch_busy", nlatch - k, 0);
        wait_latch(k);
        chk("t5_latch_lat", k, 2);
        chk("t5_idx", {30'd0, grant_idx}, 0);
        chk("t5_data", {24'd0, tx_data}, 32'hE0);
        wait_quiet();
        chk("t5_seen_n", nseen - base, 2);
        chk("t5_second", {24'd0, seen[base + 1]}, 32'hF3);
        // 6: busy held at reset release keeps the arbiter in IDLE
        force_busy = 1'b1;
        @(posedge clk);
        #1 nrst = 1'b0;
        push(0, 8'h5A, 1'b1);
        @(posedge clk);
        #1 nrst = 1'b1;
        k = nlatch;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_latch", nlatch - k, 0);
        chk("t6_idle", {31'd0, grant_active}, 0);
        force_busy = 1'b0;
        wait_latch(k);
        chk("t6_latch_lat", k, 2);
        chk("t6_data", {24'd0, tx_data}, 32'h5A);
        wait_quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
